// File: rtl/conv_job_ctrl.sv
// Convolution job sequencer: walks the output pixel grid, drains the MAC pipeline,
// pulses finish toward clk_A and waits (with timeout) for the returned acknowledge.
module conv_job_ctrl #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int K        = 3,
    parameter int PIPE_LAT = 3,
    parameter int TIMEOUT  = 200,
    parameter int CW       = 8
) (
    input  logic          clk_B,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          stall,
    input  logic          handshake,
    output logic          mac_en,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last_pix,
    output logic          finish,
    output logic          busy,
    output logic          done,
    output logic          timeout_err
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int FW    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [CW-1:0] LAST_COL   = CW'(OUT_W - 1);
    localparam logic [CW-1:0] LAST_ROW   = CW'(OUT_H - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_SIGNAL   = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t        state_r,     state_nxt_s;
    logic [CW-1:0] row_r,       row_nxt_s;
    logic [CW-1:0] col_r,       col_nxt_s;
    logic [FW-1:0] flush_cnt_r, flush_nxt_s;
    logic [CW-1:0] to_cnt_r,    to_nxt_s;
    logic          err_r,       err_nxt_s;
    logic          mac_en_s;
    logic          last_pix_s;

    // State, counters and sticky error register
    always_ff @(posedge clk_B or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            row_r       <= '0;
            col_r       <= '0;
            flush_cnt_r <= '0;
            to_cnt_r    <= '0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            row_r       <= row_nxt_s;
            col_r       <= col_nxt_s;
            flush_cnt_r <= flush_nxt_s;
            to_cnt_r    <= to_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    // Next-state and counter update; abort overrides every other transition
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        col_nxt_s   = col_r;
        flush_nxt_s = flush_cnt_r;
        to_nxt_s    = to_cnt_r;
        err_nxt_s   = err_r;
        mac_en_s    = (state_r == ST_RUN) && !stall;
        last_pix_s  = mac_en_s && (row_r == LAST_ROW) && (col_r == LAST_COL);

        if (abort) begin
            state_nxt_s = ST_IDLE;
            row_nxt_s   = '0;
            col_nxt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_RUN;
                        row_nxt_s   = '0;
                        col_nxt_s   = '0;
                        err_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Final pixel keeps row/col at their last values for the drain
                    if (last_pix_s) begin
                        state_nxt_s = ST_FLUSH;
                        flush_nxt_s = '0;
                    end else if (mac_en_s) begin
                        if (col_r == LAST_COL) begin
                            col_nxt_s = '0;
                            row_nxt_s = row_r + CW'(1);
                        end else begin
                            col_nxt_s = col_r + CW'(1);
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r == FLUSH_LAST) begin
                        state_nxt_s = ST_SIGNAL;
                    end else begin
                        flush_nxt_s = flush_cnt_r + FW'(1);
                    end
                end
                ST_SIGNAL: begin
                    to_nxt_s    = '0;
                    state_nxt_s = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // An ack on the final timeout cycle still counts as success
                    if (handshake) begin
                        state_nxt_s = ST_DONE;
                    end else if (to_cnt_r == TO_LAST) begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        to_nxt_s = to_cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    assign mac_en      = mac_en_s;
    assign last_pix    = last_pix_s;
    assign row         = row_r;
    assign col         = col_r;
    assign finish      = (state_r == ST_SIGNAL);
    assign busy        = (state_r != ST_IDLE);
    assign done        = (state_r == ST_DONE);
    assign timeout_err = err_r;

endmodule

// File: tb/tb_conv_job_ctrl.sv
// Self-checking bench for conv_job_ctrl: directed job scenarios plus randomized
// traffic, compared every cycle against a pixel-index based reference model.
module tb_conv_job_ctrl;

    localparam int IMG_W = 8, IMG_H = 8, K = 3, PIPE_LAT = 3, TIMEOUT = 200, CW = 8;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int NPIX  = OUT_W * OUT_H;
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_FLUSH = 2, PH_SIG = 3, PH_WAIT = 4, PH_DONE = 5;

    logic          clk_B = 1'b0;
    logic          rst, start, abort, stall, handshake;
    logic          mac_en, last_pix, finish, busy, done, timeout_err;
    logic [CW-1:0] row, col;

    conv_job_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIPE_LAT(PIPE_LAT), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .clk_B(clk_B), .rst(rst), .start(start), .abort(abort), .stall(stall),
        .handshake(handshake), .mac_en(mac_en), .row(row), .col(col),
        .last_pix(last_pix), .finish(finish), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk_B = ~clk_B;

    int   n_err = 0, n_chk = 0;
    // reference model: phase, linear pixel index, elapsed flush/wait cycles, error flag
    int   m_ph, m_p, m_fl, m_wt;
    logic m_err;
    // event log of the current job
    int   cyc, n_mac, n_fin, n_done, first_mac, last_cyc, fin_cyc, done_cyc;
    logic err_at_done, err_cyc1, last_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_vec();
        return {10'd0, mac_en, row, col, last_pix, finish, busy, done, timeout_err};
    endfunction

    function automatic logic [31:0] exp_vec(input logic st);
        logic          mm;
        logic [CW-1:0] r, c;
        mm = (m_ph == PH_RUN) && !st;
        r  = CW'(m_p / OUT_W);
        c  = CW'(m_p % OUT_W);
        return {10'd0, mm, r, c, mm && (m_p == NPIX - 1), (m_ph == PH_SIG),
                (m_ph != PH_IDLE), (m_ph == PH_DONE), m_err};
    endfunction

    function automatic void model_reset();
        m_ph = PH_IDLE; m_p = 0; m_fl = 0; m_wt = 0; m_err = 1'b0;
    endfunction

    function automatic void model_update(input logic s, input logic a, input logic st, input logic h);
        if (a) begin
            m_ph = PH_IDLE;
            m_p  = 0;
        end else begin
            case (m_ph)
                PH_IDLE: if (s) begin m_ph = PH_RUN; m_p = 0; m_err = 1'b0; end
                PH_RUN: begin
                    if (!st) begin
                        if (m_p == NPIX - 1) begin m_ph = PH_FLUSH; m_fl = 0; end
                        else m_p++;
                    end
                end
                PH_FLUSH: begin m_fl++; if (m_fl == PIPE_LAT) m_ph = PH_SIG; end
                PH_SIG:   begin m_wt = 0; m_ph = PH_WAIT; end
                PH_WAIT: begin
                    m_wt++;
                    if (h) m_ph = PH_DONE;
                    else if (m_wt == TIMEOUT) begin m_ph = PH_DONE; m_err = 1'b1; end
                end
                default: m_ph = PH_IDLE;
            endcase
        end
    endfunction

    function automatic void clear_log();
        n_mac = 0; n_fin = 0; n_done = 0; first_mac = -1; last_cyc = -1;
        fin_cyc = -1; done_cyc = -1; err_at_done = 1'b0; err_cyc1 = 1'bx;
    endfunction

    // One clock cycle: drive at negedge, compare, log, then advance the model at posedge
    task automatic step(input logic s, input logic a, input logic st, input logic h);
        @(negedge clk_B);
        start = s; abort = a; stall = st; handshake = h;
        #1;
        chk("outs", obs_vec(), exp_vec(st));
        last_busy = busy;
        if (cyc == 1) err_cyc1 = timeout_err;
        if (mac_en) begin n_mac++; if (first_mac < 0) first_mac = cyc; end
        if (last_pix) last_cyc = cyc;
        if (finish) begin n_fin++; fin_cyc = cyc; end
        if (done) begin n_done++; done_cyc = cyc; err_at_done = timeout_err; end
        @(posedge clk_B);
        model_update(s, a, st, h);
        cyc++;
    endtask

    task automatic run_job(input int hs_dly, input int stall_p, input int stall_len,
                           input logic hold_start, input logic noise);
        int   sl;
        logic used, st, h;
        sl = 0; used = 1'b0;
        clear_log();
        cyc = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < TIMEOUT + NPIX + 100 && n_done == 0; k++) begin
            if (!used && stall_len > 0 && m_ph == PH_RUN && m_p == stall_p) begin
                sl = stall_len; used = 1'b1;
            end
            st = (sl > 0);
            if (sl > 0) sl--;
            h = (hs_dly >= 0 && fin_cyc >= 0 && cyc == fin_cyc + hs_dly);
            if (noise && m_ph == PH_RUN && $urandom_range(0, 2) == 0) h = 1'b1;
            step(hold_start, 1'b0, st, h);
        end
        if (n_done == 0) chk("job_bound", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0; handshake = 1'b0;
        model_reset();
        clear_log();
        cyc = 0;
        #12;
        chk("reset_outs", obs_vec(), 32'd0);
        @(negedge clk_B);
        rst = 1'b0;

        // nominal job, ack 4 cycles after finish
        run_job(4, -1, 0, 1'b0, 1'b0);
        chk("nom_macs", n_mac, NPIX);
        chk("nom_first_mac", first_mac, 1);
        chk("nom_last_pix", last_cyc, NPIX);
        chk("nom_finish", fin_cyc, NPIX + PIPE_LAT + 1);
        chk("nom_fin_count", n_fin, 1);
        chk("nom_done", done_cyc, NPIX + PIPE_LAT + 1 + 5);
        chk("nom_err", err_at_done, 1'b0);

        // 5-cycle stall at (2,3)
        run_job(4, 2 * OUT_W + 3, 5, 1'b0, 1'b0);
        chk("stall_macs", n_mac, NPIX);
        chk("stall_finish", fin_cyc, NPIX + PIPE_LAT + 1 + 5);

        // no ack: timeout after TIMEOUT WAIT_ACK cycles
        run_job(-1, -1, 0, 1'b0, 1'b0);
        chk("to_done", done_cyc, NPIX + PIPE_LAT + 2 + TIMEOUT);
        chk("to_err", err_at_done, 1'b1);
        run_job(4, -1, 0, 1'b0, 1'b0);
        chk("to_err_cleared", err_cyc1, 1'b0);

        // stale acks in IDLE and RUN are ignored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("hs_idle_busy", last_busy, 1'b0);
        run_job(4, -1, 0, 1'b0, 1'b1);
        chk("hs_noise_done", done_cyc, NPIX + PIPE_LAT + 1 + 5);
        chk("hs_noise_ndone", n_done, 1);

        // abort in RUN at (1,0)
        clear_log();
        cyc = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < NPIX && !(m_ph == PH_RUN && m_p == OUT_W); k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_idle", last_busy, 1'b0);
        chk("abort_nofin", n_fin, 0);
        run_job(4, -1, 0, 1'b0, 1'b0);
        chk("after_abort_macs", n_mac, NPIX);

        // start held high through a job: single job, restart right after done
        run_job(4, -1, 0, 1'b1, 1'b0);
        chk("hold_fin_count", n_fin, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("hold_idle_after_done", last_busy, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("hold_restart", last_busy, 1'b1);

        // async reset while flushing
        for (int k = 0; k < NPIX + 10 && m_ph != PH_FLUSH; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_flush_outs", obs_vec(), 32'd0);
        model_reset();
        @(negedge clk_B);
        rst = 1'b0;

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
